// File: rtl/nco_pkg.sv
// nco_pkg: shared constants, quadrant type and quarter-wave ROM init function for the sweep NCO
package nco_pkg;
    localparam int NCO_LATENCY = 4;
    typedef logic [1:0] quad_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    // Half-step offset makes the inverted-address mirror land exactly on the reflected sample
    function automatic int rom_entry(input int k, input int out_w, input int aw);
        real a;
        a = 3.14159265358979 * (real'(k) + 0.5) / (2.0 * (2.0 ** aw));
        return $rtoi(((2.0 ** (out_w - 1)) - 1.0) * $sin(a) + 0.5);
    endfunction
endpackage

// File: rtl/nco_qw_rom.sv
// nco_qw_rom: dual-port registered quarter-wave sine ROM
// Ports: clk, reset (async, high), clken, addr_a_i/addr_b_i (LUT_AW), data_a_o/data_b_o (OUT_W-1 magnitude)
module nco_qw_rom
    import nco_pkg::*;
#(
    parameter int OUT_W  = 14,
    parameter int LUT_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic [LUT_AW-1:0] addr_a_i,
    input  logic [LUT_AW-1:0] addr_b_i,
    output logic [OUT_W-2:0]  data_a_o,
    output logic [OUT_W-2:0]  data_b_o
);
    typedef logic [OUT_W-2:0] word_t;
    word_t rom [2**LUT_AW];
    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        assign rom[k] = word_t'(rom_entry(k, OUT_W, LUT_AW));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a_o <= '0;
            data_b_o <= '0;
        end else if (clken) begin
            data_a_o <= rom[addr_a_i];
            data_b_o <= rom[addr_b_i];
        end
    end
endmodule

// File: rtl/nco_sweep_iq.sv
// nco_sweep_iq: parametrised sine/cosine NCO with phase offset, sync clear and linear chirp sweep
// Ports: clk, reset (async, high), clken (freezes all state), phi_inc_i, phase_ofs_i,
//   sweep_en_i, sweep_step_i, sweep_stop_i, sync_clr_i -> fsin_o, fcos_o, out_valid, sweep_wrap_o.
// Optional macro NCO_DITHER_EN adds LFSR dither below the phase truncation point.
module nco_sweep_iq
    import nco_pkg::*;
#(
    parameter int PHASE_W  = 32,
    parameter int OUT_W    = 14,
    parameter int LUT_AW   = 10,
    parameter int DITHER_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [PHASE_W-1:0]      phi_inc_i,
    input  logic [PHASE_W-1:0]      phase_ofs_i,
    input  logic                    sweep_en_i,
    input  logic [PHASE_W-1:0]      sweep_step_i,
    input  logic [PHASE_W-1:0]      sweep_stop_i,
    input  logic                    sync_clr_i,
    output logic signed [OUT_W-1:0] fsin_o,
    output logic signed [OUT_W-1:0] fcos_o,
    output logic                    out_valid,
    output logic                    sweep_wrap_o
);
    localparam int TW  = LUT_AW + 2;
    localparam int DSH = PHASE_W - TW - DITHER_W;
    typedef logic signed [OUT_W-1:0] smp_t;

    logic [PHASE_W-1:0]     acc_q, acc_d, inc_q, inc_d, inc_cur;
    logic [PHASE_W:0]       inc_sum;
    logic                   wrap_d;
    logic [DITHER_W-1:0]    dith;
    logic [TW-1:0]          ph_d, ph_q;
    quad_t                  sq_q, cq_q, sq3_q, cq3_q;
    logic [LUT_AW-1:0]      raw, sa_q, ca_q;
    logic [OUT_W-2:0]       srom, crom;
    smp_t                   smag, cmag;
    logic [NCO_LATENCY-1:0] vld_q;

    assign inc_cur = sweep_en_i ? inc_q : phi_inc_i;
    // One extra bit so a step that overflows PHASE_W still counts as past the stop limit
    assign inc_sum = {1'b0, inc_q} + {1'b0, sweep_step_i};

    always_comb begin
        wrap_d = !sync_clr_i && sweep_en_i && (inc_sum > {1'b0, sweep_stop_i});
        acc_d  = sync_clr_i ? '0 : acc_q + inc_cur;
        inc_d  = (sync_clr_i || !sweep_en_i || wrap_d) ? phi_inc_i : inc_sum[PHASE_W-1:0];
    end

`ifdef NCO_DITHER_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr_q <= LFSR_SEED;
        else if (clken)
            lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
    assign dith = lfsr_q[DITHER_W-1:0];
`else
    assign dith = '0;
`endif

    // Only the top LUT_AW+2 phase bits survive; dither sits just below them
    assign ph_d = TW'((acc_q + phase_ofs_i + (PHASE_W'(dith) << DSH)) >> (PHASE_W - TW));
    assign raw  = ph_q[LUT_AW-1:0];
    assign smag = smp_t'({1'b0, srom});
    assign cmag = smp_t'({1'b0, crom});
    assign out_valid = vld_q[NCO_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            inc_q        <= '0;
            sweep_wrap_o <= 1'b0;
            ph_q         <= '0;
            sq_q         <= '0;
            cq_q         <= '0;
            sa_q         <= '0;
            ca_q         <= '0;
            sq3_q        <= '0;
            cq3_q        <= '0;
            fsin_o       <= '0;
            fcos_o       <= '0;
            vld_q        <= '0;
        end else if (clken) begin
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            sweep_wrap_o <= wrap_d;
            ph_q         <= ph_d;
            sq_q         <= ph_q[TW-1 -: 2];
            cq_q         <= ph_q[TW-1 -: 2] + 2'd1;
            // Odd quadrants read the mirrored address; cosine parity is the opposite of sine
            sa_q         <= ph_q[TW-2] ? ~raw : raw;
            ca_q         <= ph_q[TW-2] ? raw : ~raw;
            sq3_q        <= sq_q;
            cq3_q        <= cq_q;
            fsin_o       <= sq3_q[1] ? -smag : smag;
            fcos_o       <= cq3_q[1] ? -cmag : cmag;
            vld_q        <= {vld_q[NCO_LATENCY-2:0], 1'b1};
        end
    end

    nco_qw_rom #(.OUT_W(OUT_W), .LUT_AW(LUT_AW)) u_rom (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .addr_a_i (sa_q),
        .addr_b_i (ca_q),
        .data_a_o (srom),
        .data_b_o (crom)
    );
endmodule
